// File: rtl/ifft64_pkg.sv
// Shared constants, bit-reverse helper and read-side state type for the
// 64-point IFFT output reorder buffer.
package ifft64_pkg;

    localparam int DW   = 16;
    localparam int N    = 64;
    localparam int LOGN = 6;
    localparam int CNTW = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

    function automatic logic [LOGN-1:0] rev6(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ifft64_out_reorder_if.sv
// FFT dual-lane input bus plus natural-order valid/ready output stream.
// master = environment side (FFT + sink), slave = the reorder block.
interface ifft64_out_reorder_if;

    logic                          start_check;
    logic [ifft64_pkg::DW-1:0]     ifft_out0_re;
    logic [ifft64_pkg::DW-1:0]     ifft_out0_im;
    logic [ifft64_pkg::DW-1:0]     ifft_out1_re;
    logic [ifft64_pkg::DW-1:0]     ifft_out1_im;
    logic                          out_valid;
    logic                          out_ready;
    logic [ifft64_pkg::DW-1:0]     out_re;
    logic [ifft64_pkg::DW-1:0]     out_im;
    logic [ifft64_pkg::LOGN-1:0]   out_index;
    logic                          out_last;

    modport master (
        output start_check, ifft_out0_re, ifft_out0_im, ifft_out1_re, ifft_out1_im,
        output out_ready,
        input  out_valid, out_re, out_im, out_index, out_last
    );

    modport slave (
        input  start_check, ifft_out0_re, ifft_out0_im, ifft_out1_re, ifft_out1_im,
        input  out_ready,
        output out_valid, out_re, out_im, out_index, out_last
    );

endinterface

// File: rtl/ifft64_pingpong_ram.sv
// Two-bank x 64-entry sample store. Split into two 32-entry halves by address
// MSB so the two lanes (which always address opposite halves) each get a port.
module ifft64_pingpong_ram
    import ifft64_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic                wbank,
    input  logic [LOGN-1:0]     waddr0,
    input  logic [LOGN-1:0]     waddr1,
    input  logic [2*DW-1:0]     wdata0,
    input  logic [2*DW-1:0]     wdata1,
    input  logic                re,
    input  logic                rbank,
    input  logic [LOGN-1:0]     raddr,
    output logic [2*DW-1:0]     rdata
);

    logic [1:0][2*DW-1:0] half_rdata;
    logic                 sel_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        logic [2*DW-1:0] mem [0:N-1];
        logic [2*DW-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (we) begin
                if (waddr0[LOGN-1] == 1'(gi)) begin
                    mem[{wbank, waddr0[LOGN-2:0]}] <= wdata0;
                end else if (waddr1[LOGN-1] == 1'(gi)) begin
                    mem[{wbank, waddr1[LOGN-2:0]}] <= wdata1;
                end
            end
            if (re) begin
                rdata_q <= mem[{rbank, raddr[LOGN-2:0]}];
            end
        end

        assign half_rdata[gi] = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (re) begin
            sel_q <= raddr[LOGN-1];
        end
    end

    assign rdata = half_rdata[sel_q];

endmodule

// File: rtl/ifft64_out_reorder.sv
// Captures bit-reversed dual-lane FFT frames into a ping-pong buffer and
// streams them out in natural order over valid/ready, dropping frames on overflow.
module ifft64_out_reorder
    import ifft64_pkg::*;
(
    input  logic                  CLK,
    input  logic                  ARSTN,
    ifft64_out_reorder_if.slave   bus,
    output logic                  overflow,
    output logic [CNTW-1:0]       frame_cnt
);

    // write side state
    logic [LOGN-2:0]  wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic             drop_q, drop_d;
    logic [1:0]       full_q, full_d;
    logic             overflow_q, overflow_d;

    // read side state
    rd_state_t        state_q, state_d;
    logic             rbank_q, rbank_d;
    logic [LOGN-1:0]  ridx_q, ridx_d;
    logic [CNTW-1:0]  fcnt_q, fcnt_d;

    logic             frame_start, tgt_busy, drop_now, we, frame_done;
    logic [LOGN-1:0]  waddr0, waddr1;
    logic             hs, at_last, rel_fire, other_full;
    logic             rd_en, rd_bank;
    logic [LOGN-1:0]  rd_addr;
    logic [2*DW-1:0]  rd_data;
    logic             valid;

    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            wcnt_q     <= '0;
            wbank_q    <= 1'b0;
            drop_q     <= 1'b0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            rbank_q    <= 1'b0;
            ridx_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            wcnt_q     <= wcnt_d;
            wbank_q    <= wbank_d;
            drop_q     <= drop_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            rbank_q    <= rbank_d;
            ridx_q     <= ridx_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign valid      = (state_q == STREAM);
    assign hs         = valid && bus.out_ready;
    assign at_last    = (ridx_q == LOGN'(N-1));
    assign rel_fire   = hs && at_last;
    assign other_full = full_q[~rbank_q];

    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (full_q[rbank_q]) state_d = STREAM;
            STREAM:  if (rel_fire && !other_full) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read address is chosen one cycle ahead so the registered RAM output
    // lines up with ridx_q; without a handshake nothing is re-read, so data holds.
    always_comb begin : p_read_ctrl
        rd_en   = 1'b0;
        rd_bank = rbank_q;
        rd_addr = ridx_q;
        ridx_d  = ridx_q;
        rbank_d = rbank_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (full_q[rbank_q]) begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    ridx_d  = '0;
                end
            end
            STREAM: begin
                if (rel_fire) begin
                    rbank_d = ~rbank_q;
                    fcnt_d  = fcnt_q + 1'b1;
                    ridx_d  = '0;
                    if (other_full) begin
                        rd_en   = 1'b1;
                        rd_bank = ~rbank_q;
                        rd_addr = '0;
                    end
                end else if (hs) begin
                    rd_en   = 1'b1;
                    rd_addr = ridx_q + 1'b1;
                    ridx_d  = ridx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A release in this cycle frees the target bank before the new frame checks it.
    always_comb begin : p_write_ctrl
        frame_start = bus.start_check && (wcnt_q == '0);
        tgt_busy    = full_q[wbank_q] && !(rel_fire && (rbank_q == wbank_q));
        drop_now    = frame_start ? tgt_busy : drop_q;
        we          = bus.start_check && !drop_now;
        frame_done  = we && (wcnt_q == '1);
        wcnt_d      = bus.start_check ? wcnt_q + 1'b1 : wcnt_q;
        drop_d      = drop_now;
        overflow_d  = overflow_q | (frame_start && tgt_busy);
        wbank_d     = frame_done ? ~wbank_q : wbank_q;
        full_d      = full_q;
        if (rel_fire) full_d[rbank_q] = 1'b0;
        if (frame_done) full_d[wbank_q] = 1'b1;
    end

    assign waddr0 = rev6({wcnt_q, 1'b0});
    assign waddr1 = rev6({wcnt_q, 1'b1});

    ifft64_pingpong_ram u_ram (
        .clk    (CLK),
        .we     (we),
        .wbank  (wbank_q),
        .waddr0 (waddr0),
        .waddr1 (waddr1),
        .wdata0 ({bus.ifft_out0_re, bus.ifft_out0_im}),
        .wdata1 ({bus.ifft_out1_re, bus.ifft_out1_im}),
        .re     (rd_en),
        .rbank  (rd_bank),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );

    assign bus.out_valid = valid;
    assign bus.out_index = ridx_q;
    assign bus.out_last  = valid && at_last;
    assign bus.out_re    = valid ? rd_data[2*DW-1:DW] : '0;
    assign bus.out_im    = valid ? rd_data[DW-1:0]    : '0;
    assign overflow      = overflow_q;
    assign frame_cnt     = fcnt_q;

endmodule

// File: tb/tb_ifft64_out_reorder.sv
// Directed scenarios with random payloads, checked against a frame-queue model
// of the reorder buffer (natural-order frames, two-slot occupancy, sticky overflow).
module tb_ifft64_out_reorder;
    import ifft64_pkg::*;

    logic             CLK = 1'b0;
    logic             ARSTN;
    logic             overflow;
    logic [CNTW-1:0]  frame_cnt;

    ifft64_out_reorder_if bus_if();

    ifft64_out_reorder dut (
        .CLK       (CLK),
        .ARSTN     (ARSTN),
        .bus       (bus_if),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [2*DW-1:0] src [N];
    logic [2*DW-1:0] exp_q [$];
    int   m_wcnt, pend_n, m_ridx, m_fcnt;
    bit   m_drop, m_ovf;
    int   pat_mode;
    bit   prev_v, prev_r;
    logic [LOGN-1:0] prev_idx;
    logic [DW-1:0]   prev_re, prev_im;
    int   n_hs, first_valid, n_coll;

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < LOGN; i++) r |= ((v >> i) & 1) << (LOGN - 1 - i);
        return r;
    endfunction

    function automatic bit rdy_pat(input int mode);
        if (mode == 0) return 1'b1;
        return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_wcnt = 0; pend_n = 0; m_ridx = 0; m_fcnt = 0;
        m_drop = 1'b0; m_ovf = 1'b0; prev_v = 1'b0; prev_r = 1'b0;
        exp_q.delete();
    endtask

    task automatic new_frame();
        for (int i = 0; i < N; i++) begin
            if (pat_mode == 1) src[i] = {16'(i), 16'(i)};
            else               src[i] = $urandom;
        end
    endtask

    task automatic tick(input bit sc, input bit rdy);
        logic [2*DW-1:0] es;
        bit v, hs, rel;
        if (sc && m_wcnt == 0) new_frame();
        bus_if.start_check = sc;
        if (sc) begin
            es = src[bitrev(2 * m_wcnt)];
            bus_if.ifft_out0_re = es[2*DW-1:DW];
            bus_if.ifft_out0_im = es[DW-1:0];
            es = src[bitrev(2 * m_wcnt + 1)];
            bus_if.ifft_out1_re = es[2*DW-1:DW];
            bus_if.ifft_out1_im = es[DW-1:0];
        end else begin
            bus_if.ifft_out0_re = 16'($urandom); bus_if.ifft_out0_im = 16'($urandom);
            bus_if.ifft_out1_re = 16'($urandom); bus_if.ifft_out1_im = 16'($urandom);
        end
        bus_if.out_ready = rdy;
        v = bus_if.out_valid;
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt % (1 << CNTW)));
        if (prev_v && !prev_r) begin
            chk("stall_valid", 32'(v), 1);
            chk("stall_index", 32'(bus_if.out_index), 32'(prev_idx));
            chk("stall_re", 32'(bus_if.out_re), 32'(prev_re));
            chk("stall_im", 32'(bus_if.out_im), 32'(prev_im));
        end
        hs = v && rdy;
        rel = 1'b0;
        if (hs) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(v), 0);
            end else begin
                es = exp_q.pop_front();
                chk("index", 32'(bus_if.out_index), 32'(m_ridx));
                chk("re", 32'(bus_if.out_re), 32'(es[2*DW-1:DW]));
                chk("im", 32'(bus_if.out_im), 32'(es[DW-1:0]));
                chk("last", 32'(bus_if.out_last), 32'(m_ridx == N - 1));
                if (m_ridx == N - 1) begin
                    rel = 1'b1; m_ridx = 0; pend_n--; m_fcnt++;
                end else begin
                    m_ridx++;
                end
            end
        end
        if (v && first_valid < 0) first_valid = cyc;
        if (sc) begin
            if (m_wcnt == 0) begin
                m_drop = (pend_n == 2);
                if (m_drop) m_ovf = 1'b1;
                if (rel) n_coll++;
            end
            if (m_wcnt == N / 2 - 1 && !m_drop) begin
                for (int i = 0; i < N; i++) exp_q.push_back(src[i]);
                pend_n++;
            end
            m_wcnt = (m_wcnt + 1) % (N / 2);
        end
        prev_v = v; prev_r = rdy;
        prev_idx = bus_if.out_index; prev_re = bus_if.out_re; prev_im = bus_if.out_im;
        @(posedge CLK); #1; cyc++;
    endtask

    task automatic drain(input int rmode);
        int t = 0;
        while ((pend_n != 0 || bus_if.out_valid) && t < 1000) begin
            tick(1'b0, rdy_pat(rmode));
            t++;
        end
        chk("drain_pending", 32'(pend_n), 0);
        chk("drain_idle", 32'(bus_if.out_valid), 0);
    endtask

    task automatic do_reset(input string tag);
        ARSTN = 1'b0;
        bus_if.start_check = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(bus_if.out_valid), 0);
        chk({tag, "_last"}, 32'(bus_if.out_last), 0);
        chk({tag, "_index"}, 32'(bus_if.out_index), 0);
        chk({tag, "_re"}, 32'(bus_if.out_re), 0);
        chk({tag, "_im"}, 32'(bus_if.out_im), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
        @(posedge CLK); #1; cyc++;
        ARSTN = 1'b1;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, hs0, t;
        bit seen;
        ARSTN = 1'b1;
        bus_if.start_check = 1'b0; bus_if.out_ready = 1'b0;
        bus_if.ifft_out0_re = '0; bus_if.ifft_out0_im = '0;
        bus_if.ifft_out1_re = '0; bus_if.ifft_out1_im = '0;
        n_hs = 0; n_coll = 0; first_valid = -1; pat_mode = 1;
        model_reset();
        @(posedge CLK); #1;
        do_reset("rst0");

        // single frame, index payload, ready high
        pat_mode = 1; t0 = cyc; hs0 = n_hs; first_valid = -1;
        repeat (32) tick(1'b1, 1'b1);
        drain(0);
        chk("t1_latency", 32'(first_valid - t0), 33);
        chk("t1_handshakes", 32'(n_hs - hs0), 64);
        chk("t1_frame_cnt", 32'(frame_cnt), 1);

        // back-pressure 1,0,0,1
        pat_mode = 0; hs0 = n_hs;
        repeat (32) tick(1'b1, rdy_pat(1));
        drain(1);
        chk("t2_handshakes", 32'(n_hs - hs0), 64);

        // start_check gap of 5 after capture 10
        t0 = cyc; first_valid = -1;
        repeat (11) tick(1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b1);
        repeat (21) tick(1'b1, 1'b1);
        drain(0);
        chk("t3_latency", 32'(first_valid - t0), 38);

        // three back-to-back frames, sink stalled until the third begins
        hs0 = n_hs;
        repeat (64) tick(1'b1, 1'b0);
        repeat (32) tick(1'b1, 1'b1);
        drain(0);
        chk("t4_overflow", 32'(overflow), 1);
        chk("t4_frame_cnt", 32'(frame_cnt), 5);
        chk("t4_handshakes", 32'(n_hs - hs0), 128);

        do_reset("rst1");

        // release of bank 0 coincides with the next frame's first capture into bank 0
        n_coll = 0;
        repeat (64) tick(1'b1, 1'b1);
        repeat (32) tick(1'b0, 1'b1);
        repeat (32) tick(1'b1, 1'b1);
        drain(0);
        chk("t5_collision", 32'(n_coll), 1);
        chk("t5_overflow", 32'(overflow), 0);
        chk("t5_frame_cnt", 32'(frame_cnt), 3);

        // reset during capture 17, then during streaming at index 30
        repeat (17) tick(1'b1, 1'b1);
        do_reset("rst2");
        repeat (32) tick(1'b1, 1'b1);
        drain(0);
        chk("t6a_frame_cnt", 32'(frame_cnt), 1);
        repeat (32) tick(1'b1, 1'b1);
        seen = 1'b0; t = 0;
        while (!seen && t < 200) begin
            if (bus_if.out_valid && bus_if.out_index == 6'd30) seen = 1'b1;
            else begin tick(1'b0, 1'b1); t++; end
        end
        chk("t6_idx30_seen", 32'(seen), 1);
        do_reset("rst3");
        repeat (32) tick(1'b1, 1'b1);
        drain(0);
        chk("t6b_frame_cnt", 32'(frame_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
